lsu_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_load_ext.sv | 22 ++
 rtl/lsu_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage.
// Holds the FSM state type, funct3 codes, byte enables and decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Stores only have the signed-looking width codes.
  function automatic logic f3_legal(
    input logic       st,
    input logic [2:0] f3
  );
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !st;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f3_nbytes(
    input logic [2:0] f3
  );
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] f3_be(
    input logic [2:0] f3
  );
    case (f3[1:0])
      2'b00:   return BE_B;
      2'b01:   return BE_H;
      default: return BE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extension: sign/zero-extends raw memory data by funct3.
// Ports: data_i raw word (lane 0 = addressed byte), funct3_i, data_o result.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_BU:   data_o = {24'd0, data_i[7:0]};
      F3_HU:   data_o = {16'd0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: one request at a time, range/funct3 checks,
// registered dataMem drive, extended load data or store ack on response.
// Ports: req_* from EX, rsp_* to consumer, mem_* to/from dataMem.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int SIZE = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_err,
  output logic [SIZE-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            mem_rd,
  output logic [3:0]      mem_wr_type,
  input  logic [31:0]     mem_rdata
);

  localparam logic [32:0] ADDR_MAX =
    (33'd1 << SIZE) - 33'd1;

  lsu_state_e      state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic            rd_q, rd_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     ext;
  logic [32:0]     last;
  logic            fault;
  logic            legal;

  // Last touched byte, 33 bits so a top-of-space address cannot wrap.
  assign last = {1'b0, req_addr}
              + {30'd0, f3_nbytes(req_funct3)}
              - 33'd1;
  assign fault = ((req_addr >> SIZE) != 32'd0)
              || (last > ADDR_MAX);
  assign legal = f3_legal(req_store, req_funct3)
              && !fault;

  lsu_load_ext u_ext (
    .data_i   (mem_rdata),
    .funct3_i (f3_q),
    .data_o   (ext)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    be_d    = 4'd0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          f3_d    = req_funct3;
          if (legal) begin
            state_d = ACCESS;
            addr_d  = req_addr[SIZE-1:0];
            if (req_store) begin
              wdata_d = req_wdata;
              be_d    = f3_be(req_funct3);
            end else begin
              rd_d = 1'b1;
            end
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            data_d  = 32'd0;
          end
        end
      end
      ACCESS: begin
        if (store_q) begin
          state_d = RESP;
          data_d  = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = RESP;
        data_d  = ext;
        err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          data_d  = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      be_q    <= be_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = data_q;
  assign rsp_err     = err_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_rd      = rd_q;
  assign mem_wr_type = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed vector table, reset corner case,
// randomized requests against a byte-array reference model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic [3:0]  mem_wr_type;
  logic [31:0] mem_rdata;
  logic        mem_clr;

  int checks = 0;
  int errors = 0;

  logic [7:0] dmem [4096];
  bit   [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  lsu_ctrl #(.SIZE(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_wr_type (mem_wr_type),
    .mem_rdata   (mem_rdata)
  );

  // dataMem stand-in: byte writes at the edge, registered 32-bit read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_wr_type[i])
          dmem[mem_addr + 12'(i)] <= mem_wdata[8*i +: 8];
    end
    if (mem_rd)
      mem_rdata <= {dmem[mem_addr + 12'd3], dmem[mem_addr + 12'd2],
                    dmem[mem_addr + 12'd1], dmem[mem_addr]};
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: byte counts, legality and extension from the rules.
  function automatic int m_n(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_err(input bit st, input logic [2:0] f3,
                               input logic [31:0] a);
    bit ok;
    longint lastb;
    ok = st ? (f3 <= 3'd2)
            : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    lastb = longint'(a) + longint'(m_n(f3)) - 1;
    return !ok || (lastb > 4095);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a);
    int n;
    longint v;
    n = m_n(f3);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v + (longint'(ref_mem[int'(a[11:0]) + i]) << (8*i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1)))
      v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic txn(input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold, input bit early,
                     input logic eerr, input logic [31:0] edata,
                     input int elat, input logic [3:0] ewr,
                     input string tag);
    int lat, wrc, rdc;
    logic [3:0] wr;
    logic abad;
    @(negedge clk);
    check({tag, " rdy"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = early;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wrc = 0; rdc = 0; wr = 4'd0; abad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_wr_type != 4'd0) begin
        wrc++;
        wr = mem_wr_type;
        if (mem_addr != a[11:0]) abad = 1'b1;
      end
      if (mem_rd) begin
        rdc++;
        if (mem_addr != a[11:0]) abad = 1'b1;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, " lat"}, lat, elat);
    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, eerr});
    check({tag, " data"}, rsp_data, edata);
    check({tag, " wr"}, {28'd0, wr}, {28'd0, ewr});
    check({tag, " wrcnt"}, wrc, (ewr != 4'd0) ? 1 : 0);
    check({tag, " rdcnt"}, rdc, (!st && !eerr) ? 1 : 0);
    check({tag, " addr"}, {31'd0, abad}, 32'd0);
    if (st && !eerr)
      for (int i = 0; i < m_n(f3); i++)
        ref_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hv"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, " hd"}, rsp_data, edata);
      check({tag, " he"}, {31'd0, rsp_err}, {31'd0, eerr});
      check({tag, " hr"}, {31'd0, req_ready}, 32'd0);
    end
    if (lat != 0) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check({tag, " idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
    end
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        eerr;
    logic [31:0] edata;
    int          elat;
    logic [3:0]  ewr;
    int          hold;
  } vec_t;

  vec_t tv [22];

  initial begin
    tv[0]  = '{1, 3'd2, 32'h010, 32'hDEADBEEF, 0, 32'h0, 2, 4'hF, 0};
    tv[1]  = '{0, 3'd2, 32'h010, 32'h0, 0, 32'hDEADBEEF, 3, 4'h0, 0};
    tv[2]  = '{1, 3'd0, 32'h021, 32'hF0, 0, 32'h0, 2, 4'h1, 0};
    tv[3]  = '{0, 3'd0, 32'h021, 32'h0, 0, 32'hFFFFFFF0, 3, 4'h0, 0};
    tv[4]  = '{0, 3'd4, 32'h021, 32'h0, 0, 32'h000000F0, 3, 4'h0, 0};
    tv[5]  = '{1, 3'd1, 32'h033, 32'h8001, 0, 32'h0, 2, 4'h3, 0};
    tv[6]  = '{0, 3'd1, 32'h033, 32'h0, 0, 32'hFFFF8001, 3, 4'h0, 0};
    tv[7]  = '{0, 3'd5, 32'h033, 32'h0, 0, 32'h00008001, 3, 4'h0, 0};
    tv[8]  = '{0, 3'd2, 32'hFFD, 32'h0, 1, 32'h0, 1, 4'h0, 0};
    tv[9]  = '{1, 3'd2, 32'hFFC, 32'h12345678, 0, 32'h0, 2, 4'hF, 0};
    tv[10] = '{0, 3'd2, 32'hFFC, 32'h0, 0, 32'h12345678, 3, 4'h0, 0};
    tv[11] = '{1, 3'd2, 32'h1000, 32'h55, 1, 32'h0, 1, 4'h0, 0};
    tv[12] = '{0, 3'd3, 32'h010, 32'h0, 1, 32'h0, 1, 4'h0, 5};
    tv[13] = '{1, 3'd4, 32'h010, 32'h77, 1, 32'h0, 1, 4'h0, 0};
    tv[14] = '{1, 3'd2, 32'h040, 32'hA5A5A5A5, 0, 32'h0, 2, 4'hF, 0};
    tv[15] = '{1, 3'd0, 32'h041, 32'h1234563C, 0, 32'h0, 2, 4'h1, 0};
    tv[16] = '{0, 3'd2, 32'h040, 32'h0, 0, 32'hA5A53CA5, 3, 4'h0, 3};
    tv[17] = '{0, 3'd1, 32'hFFE, 32'h0, 0, 32'h00001234, 3, 4'h0, 0};
    tv[18] = '{0, 3'd0, 32'hFFF, 32'h0, 0, 32'h00000012, 3, 4'h0, 0};
    tv[19] = '{1, 3'd1, 32'hFFF, 32'h99, 1, 32'h0, 1, 4'h0, 0};
    tv[20] = '{0, 3'd2, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1, 4'h0, 0};
    tv[21] = '{1, 3'd3, 32'h020, 32'h1, 1, 32'h0, 1, 4'h0, 0};

    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", {31'd0, req_ready}, 32'd1);
    check("rst valid", {31'd0, rsp_valid}, 32'd0);
    check("rst err", {31'd0, rsp_err}, 32'd0);
    check("rst data", rsp_data, 32'd0);
    check("rst rd", {31'd0, mem_rd}, 32'd0);
    check("rst wr", {28'd0, mem_wr_type}, 32'd0);
    check("rst addr", {20'd0, mem_addr}, 32'd0);
    check("rst wdata", mem_wdata, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    foreach (tv[i])
      txn(tv[i].st, tv[i].f3, tv[i].a, tv[i].wd, tv[i].hold, 1'b0,
          tv[i].eerr, tv[i].edata, tv[i].elat, tv[i].ewr,
          $sformatf("v%0d", i));

    // Reset while an LW sits in CAPTURE: the response must vanish.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0;
    req_funct3 = 3'd2; req_addr = 32'h010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid valid", {31'd0, rsp_valid}, 32'd0);
    check("mid ready", {31'd0, req_ready}, 32'd1);
    check("mid data", rsp_data, 32'd0);
    check("mid rd", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    check("mid valid2", {31'd0, rsp_valid}, 32'd0);
    txn(1'b1, 3'd0, 32'h050, 32'h7E, 0, 1'b0,
        1'b0, 32'h0, 2, 4'h1, "post sb");
    txn(1'b0, 3'd4, 32'h050, 32'h0, 0, 1'b0,
        1'b0, 32'h7E, 3, 4'h0, "post lbu");

    for (int r = 0; r < 60; r++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a, wd, ed;
      logic        ee;
      int          el;
      logic [3:0]  ew;
      int          sel;
      st  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 7) a = 32'($urandom_range(0, 4095));
      else if (sel == 7) a = 32'(4092 + $urandom_range(0, 3));
      else if (sel == 8) a = 32'(4096 + $urandom_range(0, 255));
      else a = $urandom;
      ee = m_err(st, f3, a);
      ed = (ee || st) ? 32'd0 : m_load(f3, a);
      el = ee ? 1 : (st ? 2 : 3);
      ew = (ee || !st) ? 4'd0 : 4'((1 << m_n(f3)) - 1);
      txn(st, f3, a, wd, 0, 1'($urandom_range(0, 1)),
          ee, ed, el, ew, $sformatf("r%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
